spi_nor_responder: RTL and testbench



---
 rtl/spi_nor_responder.sv | 164 ++++++++++++++++
 tb/tb_spi_nor_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_nor_responder.sv
// spi_nor_responder
// Flash-side responder for the APB-to-SPI controller's byte-lane frame:
// one command byte, three address bytes (MSB first), four data bytes.
// Writes are committed into a small word array, and reads return the stored
// word one byte per s_clk period on s_miso.

module spi_nor_responder #(
    parameter int AW = 4
) (
    input  logic       p_clk,
    input  logic       p_reset,
    input  logic       s_clk,
    input  logic       s_css,
    input  logic [7:0] s_mosi,
    output logic [7:0] s_miso,
    output logic       wr_done,
    output logic       rd_done,
    output logic       cmd_err
);

    localparam int DEPTH = 1 << AW;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_RDATA  = 3'd3;
    localparam logic [2:0] ST_WDATA  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_IGNORE = 3'd6;

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    logic          s_clk_q;
    logic          rise;
    logic [2:0]    state;
    logic [2:0]    bidx;
    logic          is_read;
    // Only the low AW bits of the 24-bit address select a word. Shifting the
    // address bytes through an AW-bit register drops the upper bits as they
    // arrive, which gives the modulo-2^AW wrap directly.
    logic [AW-1:0] addr_idx;
    logic [AW-1:0] idx_next;
    logic [23:0]   wbuf;
    logic [23:0]   rbuf;
    logic [31:0]   rd_word;
    logic [31:0]   wr_word;
    logic          commit;
    logic [31:0]   mem [DEPTH];

    // Chip select is folded into the edge detect, so a rise coinciding with
    // s_css going high is dropped.
    assign rise     = s_clk & ~s_clk_q & ~s_css;
    assign idx_next = AW'({addr_idx, s_mosi});
    assign rd_word  = mem[idx_next];
    assign wr_word  = {wbuf, s_mosi};
    assign commit   = rise && (state == ST_WDATA) && (bidx == 3'd7);

    // Previous s_clk sample for rising-edge detection.
    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            s_clk_q <= 1'b0;
        end else begin
            s_clk_q <= s_clk;
        end
    end

    // Frame byte index: cleared between frames, saturates at the last byte.
    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            bidx <= 3'd0;
        end else if (s_css) begin
            bidx <= 3'd0;
        end else if (rise && (bidx != 3'd7)) begin
            bidx <= bidx + 3'd1;
        end
    end

    // Frame decoder: command, address and data phases, s_miso and pulses.
    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            state    <= ST_IDLE;
            is_read  <= 1'b0;
            addr_idx <= '0;
            wbuf     <= '0;
            rbuf     <= '0;
            s_miso   <= 8'h00;
            wr_done  <= 1'b0;
            rd_done  <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            rd_done <= 1'b0;
            cmd_err <= 1'b0;
            if (s_css) begin
                state  <= ST_IDLE;
                s_miso <= 8'h00;
            end else if (rise) begin
                case (state)
                    ST_IDLE: begin
                        if (s_mosi == CMD_READ) begin
                            state   <= ST_CMD;
                            is_read <= 1'b1;
                        end else if (s_mosi == CMD_WRITE) begin
                            state   <= ST_CMD;
                            is_read <= 1'b0;
                        end else begin
                            state   <= ST_IGNORE;
                            cmd_err <= 1'b1;
                        end
                    end
                    ST_CMD: begin
                        addr_idx <= idx_next;
                        state    <= ST_ADDR;
                    end
                    ST_ADDR: begin
                        addr_idx <= idx_next;
                        if (bidx == 3'd3) begin
                            if (is_read) begin
                                state  <= ST_RDATA;
                                rbuf   <= rd_word[23:0];
                                s_miso <= rd_word[31:24];
                            end else begin
                                state <= ST_WDATA;
                            end
                        end
                    end
                    ST_RDATA: begin
                        case (bidx)
                            3'd4: s_miso <= rbuf[23:16];
                            3'd5: s_miso <= rbuf[15:8];
                            3'd6: begin
                                s_miso  <= rbuf[7:0];
                                rd_done <= 1'b1;
                            end
                            3'd7: state <= ST_DONE;
                            default: ;
                        endcase
                    end
                    ST_WDATA: begin
                        wbuf <= wr_word[23:0];
                        if (bidx == 3'd7) begin
                            state   <= ST_DONE;
                            wr_done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Word array: cleared on reset, written once the 4th data byte arrives.
    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (commit) begin
            mem[addr_idx] <= wr_word;
        end
    end

endmodule

// File: tb/tb_spi_nor_responder.sv
// tb_spi_nor_responder
// Table-driven directed frames, hand-written reset/idle sequences and
// randomized frames checked against a frame-level model of the responder.

module tb_spi_nor_responder;

    logic       p_clk;
    logic       p_reset;
    logic       s_clk;
    logic       s_css;
    logic [7:0] s_mosi;
    logic [7:0] s_miso;
    logic       wr_done;
    logic       rd_done;
    logic       cmd_err;

    int tests_run;
    int tests_failed;
    int wr_cnt;
    int rd_cnt;
    int err_cnt;

    logic [31:0] model_mem [16];

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        logic [31:0] data;
        int          nbytes;
        logic [63:0] exp_miso;
        int          exp_wr;
        int          exp_rd;
        int          exp_err;
        string       name;
    } vec_t;

    vec_t vecs[8];

    spi_nor_responder #(.AW(4)) dut (
        .p_clk   (p_clk),
        .p_reset (p_reset),
        .s_clk   (s_clk),
        .s_css   (s_css),
        .s_mosi  (s_mosi),
        .s_miso  (s_miso),
        .wr_done (wr_done),
        .rd_done (rd_done),
        .cmd_err (cmd_err)
    );

    // 10 ns system clock.
    initial p_clk = 1'b0;
    always #5 p_clk = ~p_clk;

    // Count single-cycle pulses, sampled mid-cycle.
    always @(negedge p_clk) begin
        if (wr_done) wr_cnt++;
        if (rd_done) rd_cnt++;
        if (cmd_err) err_cnt++;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One byte: s_clk high two cycles, low two cycles; s_miso read at the end.
    task automatic sendByte(input logic [7:0] b, output logic [7:0] miso);
        s_mosi = b;
        s_clk  = 1'b1;
        repeat (2) @(negedge p_clk);
        s_clk = 1'b0;
        repeat (2) @(negedge p_clk);
        miso = s_miso;
    endtask

    // Full or truncated frame followed by a chip-select-high gap.
    task automatic applyStimulus(input logic [63:0] frame, input int nbytes, input int gap,
                                 output logic [63:0] miso_seen, output int wr_n,
                                 output int rd_n, output int err_n);
        int wr0;
        int rd0;
        int err0;
        logic [7:0] m;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        err0 = err_cnt;
        miso_seen = '0;
        s_css = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            sendByte(frame[63-8*i -: 8], m);
            miso_seen[63-8*i -: 8] = m;
        end
        s_css = 1'b1;
        repeat (gap) @(negedge p_clk);
        wr_n = wr_cnt - wr0;
        rd_n = rd_cnt - rd0;
        err_n = err_cnt - err0;
    endtask

    // Frame-level model: what each byte slot should show and which pulses
    // the frame should produce; memory updated for complete writes only.
    function automatic void model_apply(input logic [7:0] cmd, input logic [23:0] addr,
                                        input logic [31:0] data, input int nbytes,
                                        output logic [63:0] exp_miso, output int exp_wr,
                                        output int exp_rd, output int exp_err);
        int idx;
        int k;
        logic [31:0] word;
        idx = int'(addr) % 16;
        word = model_mem[idx];
        exp_miso = '0;
        exp_wr = 0;
        exp_rd = 0;
        exp_err = 0;
        if (nbytes < 1) return;
        if (cmd == 8'h01) begin
            for (int i = 3; i < nbytes; i++) begin
                k = (i > 6) ? 3 : i - 3;
                exp_miso[63-8*i -: 8] = word[31-8*k -: 8];
            end
            if (nbytes >= 7) exp_rd = 1;
        end else if (cmd == 8'h02) begin
            if (nbytes == 8) begin
                model_mem[idx] = data;
                exp_wr = 1;
            end
        end else begin
            exp_err = 1;
        end
    endfunction

    initial begin
        logic [63:0] miso_seen;
        logic [63:0] exp_miso;
        logic [7:0]  m;
        logic [7:0]  cmd;
        logic [23:0] addr;
        logic [31:0] data;
        int wr_n, rd_n, err_n;
        int exp_wr, exp_rd, exp_err;
        int nb, gap, sel;

        tests_run = 0;
        tests_failed = 0;
        wr_cnt = 0;
        rd_cnt = 0;
        err_cnt = 0;
        for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;

        vecs[0] = '{8'h02, 24'h000005, 32'hDEADBEEF, 8, 64'h0, 1, 0, 0, "write_w5"};
        vecs[1] = '{8'h01, 24'h000005, 32'h0, 8, 64'h000000DEADBEEFEF, 0, 1, 0, "read_w5"};
        vecs[2] = '{8'h02, 24'h000113, 32'h11223344, 8, 64'h0, 1, 0, 0, "write_wrap"};
        vecs[3] = '{8'h01, 24'h000003, 32'h0, 8, 64'h0000001122334444, 0, 1, 0, "read_w3"};
        vecs[4] = '{8'h02, 24'h000007, 32'hAABBCCDD, 6, 64'h0, 0, 0, 0, "write_abort"};
        vecs[5] = '{8'h01, 24'h000007, 32'h0, 8, 64'h0, 0, 1, 0, "read_w7"};
        vecs[6] = '{8'h9F, 24'h000005, 32'h12345678, 8, 64'h0, 0, 0, 1, "bad_cmd"};
        vecs[7] = '{8'h01, 24'h000005, 32'h0, 8, 64'h000000DEADBEEFEF, 0, 1, 0, "reread_w5"};

        p_reset = 1'b1;
        s_clk = 1'b0;
        s_css = 1'b1;
        s_mosi = 8'h00;
        repeat (3) @(negedge p_clk);
        checkOutput("reset_miso", {56'h0, s_miso}, 64'h0);
        checkOutput("reset_pulses", {61'h0, wr_done, rd_done, cmd_err}, 64'h0);
        p_reset = 1'b0;
        repeat (2) @(negedge p_clk);

        // Reset in the middle of a read frame clears s_miso and the array.
        applyStimulus({8'h02, 24'h000005, 32'hCAFEF00D}, 8, 1, miso_seen, wr_n, rd_n, err_n);
        model_apply(8'h02, 24'h000005, 32'hCAFEF00D, 8, exp_miso, exp_wr, exp_rd, exp_err);
        checkOutput("pre_reset_wr", 64'(wr_n), 64'(exp_wr));
        s_css = 1'b0;
        sendByte(8'h01, m);
        sendByte(8'h00, m);
        sendByte(8'h00, m);
        sendByte(8'h05, m);
        sendByte(8'h00, m);
        checkOutput("pre_reset_miso", {56'h0, m}, 64'hFE);
        s_clk = 1'b1;
        @(negedge p_clk);
        p_reset = 1'b1;
        #1;
        checkOutput("async_reset_miso", {56'h0, s_miso}, 64'h0);
        @(negedge p_clk);
        checkOutput("mid_reset_pulses", {61'h0, wr_done, rd_done, cmd_err}, 64'h0);
        s_clk = 1'b0;
        s_css = 1'b1;
        p_reset = 1'b0;
        for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
        repeat (2) @(negedge p_clk);
        applyStimulus({8'h01, 24'h000005, 32'h0}, 8, 1, miso_seen, wr_n, rd_n, err_n);
        checkOutput("post_reset_read_w5", miso_seen, 64'h0);

        // Directed frames, back to back with a one-cycle chip-select gap.
        for (int v = 0; v < 8; v++) begin
            applyStimulus({vecs[v].cmd, vecs[v].addr, vecs[v].data}, vecs[v].nbytes, 1,
                          miso_seen, wr_n, rd_n, err_n);
            model_apply(vecs[v].cmd, vecs[v].addr, vecs[v].data, vecs[v].nbytes,
                        exp_miso, exp_wr, exp_rd, exp_err);
            checkOutput({vecs[v].name, "_miso"}, miso_seen, vecs[v].exp_miso);
            checkOutput({vecs[v].name, "_wr"}, 64'(wr_n), 64'(vecs[v].exp_wr));
            checkOutput({vecs[v].name, "_rd"}, 64'(rd_n), 64'(vecs[v].exp_rd));
            checkOutput({vecs[v].name, "_err"}, 64'(err_n), 64'(vecs[v].exp_err));
        end

        // s_clk activity with chip select high must do nothing.
        wr_n = wr_cnt;
        rd_n = rd_cnt;
        err_n = err_cnt;
        s_css = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sendByte((i == 0) ? 8'h02 : 8'h77, m);
            checkOutput($sformatf("idle_clk_miso_%0d", i), {56'h0, m}, 64'h0);
        end
        checkOutput("idle_clk_pulses", 64'((wr_cnt - wr_n) + (rd_cnt - rd_n) + (err_cnt - err_n)), 64'h0);
        applyStimulus({8'h01, 24'h000007, 32'h0}, 8, 1, miso_seen, wr_n, rd_n, err_n);
        checkOutput("idle_clk_w7_unchanged", miso_seen, 64'h0);

        // Randomized frames against the model.
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 9);
            addr = 24'($urandom);
            data = $urandom;
            nb = 8;
            if (sel <= 3) begin
                cmd = 8'h02;
            end else if (sel <= 7) begin
                cmd = 8'h01;
                if (sel == 7) nb = $urandom_range(1, 8);
            end else if (sel == 8) begin
                cmd = 8'($urandom);
                if (cmd == 8'h01 || cmd == 8'h02) cmd = 8'hFF;
            end else begin
                cmd = 8'h02;
                nb = $urandom_range(1, 7);
            end
            gap = $urandom_range(1, 3);
            applyStimulus({cmd, addr, data}, nb, gap, miso_seen, wr_n, rd_n, err_n);
            model_apply(cmd, addr, data, nb, exp_miso, exp_wr, exp_rd, exp_err);
            checkOutput($sformatf("rand%0d_miso", t), miso_seen, exp_miso);
            checkOutput($sformatf("rand%0d_pulses", t), {wr_n[7:0], rd_n[7:0], err_n[7:0]},
                        {exp_wr[7:0], exp_rd[7:0], exp_err[7:0]});
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
